// File: rtl/axis_sig_chk_if.sv
// AXI-stream style handshake bundle (vld/rdy/data/last) shared by sources and sinks.
interface axis_if #(
    parameter int unsigned DATAW = 64
) ();
    logic             vld;
    logic             rdy;
    logic [DATAW-1:0] data;
    logic             last;

    modport master (output vld, output data, output last, input rdy);
    modport slave  (input vld, input data, input last, output rdy);
endinterface

// File: rtl/axis_sig_chk.sv
// Stream sink that folds each frame into a MISR signature, counts frames and
// flags framing / signature faults with sticky error bits.
module axis_sig_chk #(
    parameter int unsigned N        = 16,
    parameter int unsigned DATAW    = 64,
    parameter logic [63:0] SEED     = 64'hFEDCBA9876543210,
    parameter logic [63:0] POLY     = 64'hD800000000000000,
    parameter bit          STALL_EN = 1'b0
) (
    input  logic             clk,
    input  logic             s_rst_n,
    axis_if.slave            z_in,
    input  logic [DATAW-1:0] exp_sig,
    input  logic             exp_en,
    input  logic             err_clr,
    output logic [DATAW-1:0] sig,
    output logic             sig_vld,
    output logic [31:0]      frame_cnt,
    output logic             err_len,
    output logic             err_sig,
    output logic             busy
);

    localparam int unsigned      CNTW     = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNTW-1:0]  LAST_IDX = CNTW'(N - 1);
    localparam logic [DATAW-1:0] SEED_W   = DATAW'(SEED);
    localparam logic [DATAW-1:0] POLY_W   = DATAW'(POLY);
    localparam logic [15:0]      LFSR_SEED = 16'hACE1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RECV = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNTW-1:0]  beat_cnt;
    logic [DATAW-1:0] acc;

    logic             accept_c;
    logic             at_end_c;
    logic             close_c;
    logic             len_bad_c;
    logic             sig_bad_c;
    logic [DATAW-1:0] acc_next_c;

    // Handshake decode, MISR step and close/error conditions for the current beat.
    always_comb begin
        accept_c   = z_in.vld && z_in.rdy;
        at_end_c   = (beat_cnt == LAST_IDX);
        acc_next_c = {acc[DATAW-2:0], ^(acc & POLY_W)} ^ z_in.data;
        close_c    = accept_c && (z_in.last || at_end_c);
        // Early last or missing last: last and the end-of-frame count disagree.
        len_bad_c  = accept_c && (z_in.last != at_end_c);
        sig_bad_c  = close_c && exp_en && (acc_next_c != exp_sig);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a frame is open between its first and closing beats.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept_c && !close_c) state_d = S_RECV;
            S_RECV: if (close_c)              state_d = S_IDLE;
            default:                          state_d = S_IDLE;
        endcase
    end

    // FSM output decode.
    always_comb begin
        busy = (state_q == S_RECV);
    end

    // Beat counter, MISR accumulator, signature capture, frame count and sticky errors.
    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            beat_cnt  <= '0;
            acc       <= SEED_W;
            sig       <= '0;
            sig_vld   <= 1'b0;
            frame_cnt <= '0;
            err_len   <= 1'b0;
            err_sig   <= 1'b0;
        end else begin
            sig_vld <= close_c;
            if (close_c) begin
                beat_cnt  <= '0;
                acc       <= SEED_W;
                sig       <= acc_next_c;
                frame_cnt <= frame_cnt + 32'd1;
            end else if (accept_c) begin
                beat_cnt <= beat_cnt + CNTW'(1);
                acc      <= acc_next_c;
            end
            // A new fault in the same cycle as a clear still sets the flag.
            err_len <= len_bad_c | (err_len & ~err_clr);
            err_sig <= sig_bad_c | (err_sig & ~err_clr);
        end
    end

    generate
        if (STALL_EN) begin : g_stall
            logic [15:0] lfsr;
            logic        fb_c;

            // Fibonacci taps for x^16+x^14+x^13+x^11+1 in right-shift form.
            always_comb begin
                fb_c = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
            end

            // Pseudo-random back-pressure: rdy follows the LFSR low bit, one cycle late.
            always_ff @(posedge clk) begin
                if (!s_rst_n) begin
                    lfsr     <= LFSR_SEED;
                    z_in.rdy <= 1'b0;
                end else begin
                    lfsr     <= {fb_c, lfsr[15:1]};
                    z_in.rdy <= lfsr[0];
                end
            end
        end else begin : g_nostall
            // Always ready once out of reset.
            always_ff @(posedge clk) begin
                if (!s_rst_n) begin
                    z_in.rdy <= 1'b0;
                end else begin
                    z_in.rdy <= 1'b1;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_axis_sig_chk.sv
// Bench for axis_sig_chk: one always-ready instance and one throttled instance,
// frame table plus hand sequences, scoreboard checked on every sig_vld.
module tb_axis_sig_chk;

    localparam int unsigned N     = 16;
    localparam int unsigned DATAW = 64;
    localparam logic [63:0] SEED  = 64'hFEDCBA9876543210;
    localparam logic [63:0] POLY  = 64'hD800000000000000;

    typedef struct {
        int          nb;
        int          last_at;
        logic [63:0] dbase;
        logic [63:0] dmul;
        bit          en;
        logic [63:0] flip;
        bit          clr;
        bit          el;
        bit          es;
    } vec_t;

    typedef struct {
        logic [63:0] sig;
        int unsigned fc;
        bit          el;
        bit          es;
        int unsigned cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        s_rst_n, sel, vld, last, exp_en, err_clr;
    logic [63:0] data, exp_sig;

    axis_if #(.DATAW(DATAW)) z0 ();
    axis_if #(.DATAW(DATAW)) z1 ();

    assign z0.vld  = vld & ~sel;
    assign z0.data = data;
    assign z0.last = last;
    assign z1.vld  = vld & sel;
    assign z1.data = data;
    assign z1.last = last;

    logic [63:0] sig0, sig1;
    logic        sig_vld0, sig_vld1, el0, el1, es0, es1, busy0, busy1;
    logic [31:0] fc0, fc1;

    axis_sig_chk #(.N(N), .DATAW(DATAW), .SEED(SEED), .POLY(POLY), .STALL_EN(1'b0)) u_dut0 (
        .clk(clk), .s_rst_n(s_rst_n), .z_in(z0), .exp_sig(exp_sig), .exp_en(exp_en),
        .err_clr(err_clr), .sig(sig0), .sig_vld(sig_vld0), .frame_cnt(fc0),
        .err_len(el0), .err_sig(es0), .busy(busy0));

    axis_sig_chk #(.N(N), .DATAW(DATAW), .SEED(SEED), .POLY(POLY), .STALL_EN(1'b1)) u_dut1 (
        .clk(clk), .s_rst_n(s_rst_n), .z_in(z1), .exp_sig(exp_sig), .exp_en(exp_en),
        .err_clr(err_clr), .sig(sig1), .sig_vld(sig_vld1), .frame_cnt(fc1),
        .err_len(el1), .err_sig(es1), .busy(busy1));

    logic [63:0] sig_m;
    logic        sig_vld_m, el_m, es_m, busy_m, rdy_m;
    logic [31:0] fc_m;

    always_comb begin
        sig_m     = sel ? sig1     : sig0;
        sig_vld_m = sel ? sig_vld1 : sig_vld0;
        el_m      = sel ? el1      : el0;
        es_m      = sel ? es1      : es0;
        busy_m    = sel ? busy1    : busy0;
        rdy_m     = sel ? z1.rdy   : z0.rdy;
        fc_m      = sel ? fc1      : fc0;
    end

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc    = 0;
    int unsigned fc_model = 0;
    exp_t        sbq[$];
    vec_t        tbl[10];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] misr(input logic [63:0] acc, input logic [63:0] d);
        return {acc[62:0], ^(acc & POLY)} ^ d;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every sig_vld must match the oldest expected close.
    always @(negedge clk) begin
        exp_t e;
        if (sig_vld_m !== 1'b0) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_sig_vld: got %b expected 0 (t=%0t)", sig_vld_m, $time);
            end else begin
                e = sbq.pop_front();
                check("sig", sig_m, e.sig);
                check("frame_cnt", 64'(fc_m), 64'(e.fc));
                check("err_len_at_close", 64'(el_m), 64'(e.el));
                check("err_sig_at_close", 64'(es_m), 64'(e.es));
                check("sig_vld_latency", 64'(cyc), 64'(e.cyc + 1));
            end
        end
    end

    // Bounded wait (called at a negedge) until the selected sink is ready.
    task automatic wait_rdy();
        int n = 0;
        while (rdy_m !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (rdy_m !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL rdy_timeout: got %b expected 1 (t=%0t)", rdy_m, $time);
        end
    endtask

    task automatic send_frame(input vec_t v);
        logic [63:0] acc = SEED;
        logic [63:0] d;
        bit          l, closing;
        exp_t        e;
        for (int i = 0; i < v.nb; i++) begin
            d       = v.dbase + 64'(i) * v.dmul;
            l       = (i == v.last_at);
            closing = l || (i == int'(N) - 1);
            acc     = misr(acc, d);
            vld     = 1'b1;
            data    = d;
            last    = l;
            if (closing) begin
                exp_sig = acc ^ v.flip;
                exp_en  = v.en;
                err_clr = v.clr;
            end
            wait_rdy();
            if (closing) begin
                fc_model++;
                e.sig = acc; e.fc = fc_model; e.el = v.el; e.es = v.es; e.cyc = cyc;
                sbq.push_back(e);
            end
            @(negedge clk);
            exp_en  = 1'b0;
            err_clr = 1'b0;
            check("busy_after_beat", 64'(busy_m), 64'(!closing));
        end
        vld  = 1'b0;
        last = 1'b0;
    endtask

    task automatic clr_pulse(input bit exp_es_after);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("err_len_cleared", 64'(el_m), 64'd0);
        check("err_sig_after_clr", 64'(es_m), 64'(exp_es_after));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rdy"}, 64'(rdy_m), 64'd0);
        check({tag, "_sig"}, sig_m, 64'd0);
        check({tag, "_sig_vld"}, 64'(sig_vld_m), 64'd0);
        check({tag, "_frame_cnt"}, 64'(fc_m), 64'd0);
        check({tag, "_err_len"}, 64'(el_m), 64'd0);
        check({tag, "_err_sig"}, 64'(es_m), 64'd0);
        check({tag, "_busy"}, 64'(busy_m), 64'd0);
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", 64'(sbq.size()), 64'd0);
    endtask

    initial begin
        vec_t v;
        //        nb  last data_base               mul        en flip clr el es
        tbl[0] = '{16, 15, 64'h0,                   64'h1,     0, 64'h0, 0, 0, 0};
        tbl[1] = '{10,  9, 64'h100,                 64'h3,     0, 64'h0, 0, 1, 0};
        tbl[2] = '{16, 15, 64'hDEAD_BEEF_0000_0000, 64'h0101,  0, 64'h0, 0, 1, 0};
        tbl[3] = '{16, 99, 64'h5555_0000_AAAA_0000, 64'h11,    0, 64'h0, 0, 1, 0};
        tbl[4] = '{16, 15, 64'h0123_4567_89AB_CDEF, 64'hF00D,  1, 64'h0, 0, 0, 0};
        tbl[5] = '{16, 15, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7,     1, 64'h1, 0, 0, 1};
        tbl[6] = '{16, 15, 64'h8000_0000_0000_0001, 64'h2,     1, 64'h1, 1, 0, 1};
        tbl[7] = '{16, 15, 64'h1357_9BDF_2468_ACE0, 64'h5,     1, 64'h0, 1, 0, 0};
        tbl[8] = '{ 1,  0, 64'hCAFE_F00D,           64'h0,     0, 64'h0, 0, 1, 0};
        tbl[9] = '{ 2,  1, 64'h42,                  64'h1,     1, 64'h0, 0, 1, 0};

        s_rst_n = 1'b0; sel = 1'b0; vld = 1'b1; last = 1'b0; data = '0;
        exp_en = 1'b0; err_clr = 1'b0; exp_sig = '0;

        // Reset held 5 cycles with vld high: nothing accepted, rdy low.
        repeat (5) @(negedge clk);
        check_reset_outputs("reset");
        s_rst_n = 1'b1;
        vld     = 1'b0;
        @(negedge clk);
        check("rdy_after_reset", 64'(rdy_m), 64'd1);
        check("busy_after_reset", 64'(busy_m), 64'd0);
        check("frame_cnt_after_reset", 64'(fc_m), 64'd0);

        // Table frames, back to back, with clears after the framing-error rows.
        for (int i = 0; i < 10; i++) begin
            send_frame(tbl[i]);
            if (i == 2 || i == 3) begin
                @(negedge clk);
                clr_pulse(1'b0);
            end
        end
        drain();
        @(negedge clk);
        check("sig_vld_single_pulse", 64'(sig_vld_m), 64'd0);

        // Throttled instance: fresh reset, then 3 clean frames with stalls.
        sel     = 1'b1;
        s_rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("stall_reset");
        s_rst_n  = 1'b1;
        fc_model = 0;
        @(negedge clk);
        v = tbl[0]; send_frame(v);
        v = tbl[2]; v.el = 1'b0; send_frame(v);
        v = tbl[4]; v.en = 1'b0; send_frame(v);
        drain();
        check("stall_frame_cnt", 64'(fc_m), 64'd3);

        // Frame 4: beats 0..6 accepted, reset in place of beat 7.
        v = tbl[5]; v.nb = 7; v.last_at = 99; v.en = 1'b0; v.es = 1'b0;
        send_frame(v);
        vld     = 1'b1;
        s_rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vld     = 1'b0;
        check_reset_outputs("midframe_reset");
        s_rst_n  = 1'b1;
        fc_model = 0;
        @(negedge clk);
        check("sig_vld_after_midframe_reset", 64'(sig_vld_m), 64'd0);
        v = tbl[7]; v.en = 1'b0; v.clr = 1'b0;
        send_frame(v);
        drain();
        check("final_frame_cnt", 64'(fc_m), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_sig_chk.md
# axis_sig_chk

AXI-stream sink and signature checker for the result stream of the polynomial multiplier. It sits opposite the `axis_gen` LFSR sources in synthesis and bring-up tops, and consumes `z` with optional pseudo-random back-pressure. It compresses each N-coefficient frame into a MISR signature, counts frames, and raises sticky errors for framing faults and signature mismatches.

## Interface
Parameters:
- N, 16, coefficients per frame (N ≥ 2)
- DATAW, 64, data width of the stream
- SEED, 64'hFEDCBA9876543210, MISR initial value (low DATAW bits used)
- POLY, 64'hD800000000000000, MISR feedback tap mask (low DATAW bits used)
- STALL_EN, 0, 1 = throttle `rdy` with an internal LFSR; 0 = always ready

Ports:
- clk  in  1  sole clock
- s_rst_n  in  1  synchronous reset, active low
- z_in  axis_if #(DATAW) slave  input stream; fields vld, rdy, data, last; this block drives rdy
- exp_sig  in  DATAW  expected frame signature
- exp_en  in  1  enable signature compare at frame close
- err_clr  in  1  clear sticky error flags
- sig  out  DATAW  signature of the last closed frame
- sig_vld  out  1  one-cycle pulse when `sig` updates
- frame_cnt  out  32  number of closed frames, wraps at 2^32
- err_len  out  1  sticky framing error
- err_sig  out  1  sticky signature mismatch
- busy  out  1  a frame is open

## Operation
- Beat accepted iff vld && rdy on a rising edge. data and last are ignored otherwise.
- State machine:
  - IDLE: no frame open.
  - RECV: frame open.
  - IDLE → RECV on an accepted beat that does not close the frame.
  - RECV → IDLE on the closing beat.
  - A single-beat frame (early last at beat 0) stays in IDLE.
  - busy = (state == RECV).
- beat_cnt, width $clog2(N), counts accepted beats within the frame.
- acc is the MISR accumulator. Per accepted beat: acc_next = ({acc[DATAW-2:0], ^(acc & POLY)}) ^ data. The first beat of a frame uses SEED as acc.
- A frame closes on the accepted beat where last = 1 OR beat_cnt = N-1.
  - last = 1 with beat_cnt < N-1: err_len set (early last).
  - beat_cnt = N-1 with last = 0: err_len set (missing last). The frame still closes.
  - On close: sig ← acc_next, frame_cnt += 1, beat_cnt ← 0, acc ← SEED.
- Signature compare at close: if exp_en = 1 and acc_next ≠ exp_sig, set err_sig. exp_sig and exp_en are sampled on the closing beat.
- err_clr clears err_len and err_sig. If a set and err_clr occur in the same cycle, the set wins.
- rdy generation:
  - STALL_EN = 0: rdy is registered, 0 in reset and 1 from the first cycle after reset.
  - STALL_EN = 1: 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1), seed 16'hACE1, steps every cycle. rdy = registered LFSR bit 0 and is 0 in reset.
- rdy may fall while vld is high. No data is buffered, so nothing can be lost.

## Timing
- Reset values:
  - rdy = 0, sig = 0, sig_vld = 0, frame_cnt = 0, err_len = 0, err_sig = 0, busy = 0.
  - state = IDLE, beat_cnt = 0, acc = SEED, stall LFSR = 16'hACE1.
- Reset mid-frame discards the partial frame. No sig_vld or error is produced for it.
- sig, sig_vld, frame_cnt, err_len and err_sig are all registered. They update in the cycle after the closing beat's edge, so latency from closing beat to sig_vld is 1 cycle.
- Back-to-back frames: beat 0 of the next frame may be accepted on the cycle sig_vld is high. sig holds until the next close.
- Throughput is 1 beat/cycle when STALL_EN = 0.

## Test plan
- Reset: hold s_rst_n = 0 for 5 cycles with vld = 1 → all outputs at reset values and rdy = 0. First cycle after release: rdy = 1, and no beat was accepted during reset.
- Nominal frame (N=16, STALL_EN=0, exp_en=0): 16 beats of data = beat index 0..15, last on beat 15 → sig equals the reference-model MISR over that data from SEED. sig_vld pulses exactly 1 cycle after beat 15. frame_cnt = 1, err_len = 0, and busy falls with the close.
- Early last: last on beat 9 → err_len = 1 and sig_vld 1 cycle later with a 10-beat signature. The next 16 beats, with last on beat 15, form a clean frame and frame_cnt = 2.
- Missing last: 16 beats with last = 0 → err_len = 1 and the frame closes at beat 15. Then assert err_clr for one cycle → err_len = 0.
- Signature check: exp_en = 1 with exp_sig = the correct value → err_sig stays 0. Repeat with exp_sig = correct ^ 1 → err_sig = 1. Assert err_clr in the same cycle as a new mismatch → err_sig stays 1.
- Stall and mid-frame reset: STALL_EN = 1 with vld held high over 3 frames → signatures match the STALL_EN = 0 run and frame_cnt = 3. Assert reset at beat 7 of frame 4 → frame_cnt = 0 and no sig_vld. After reset, a new 16-beat frame closes normally.
